// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
package int_ctrl_pkg;

    localparam int unsigned NUM_IRQ_DEF = 3;
    localparam int unsigned ID_W        = 2;
    localparam int unsigned CFG_AW      = 2;
    localparam int unsigned CFG_DW      = 8;
    localparam int unsigned VEC_W       = 16;

    localparam logic [CFG_AW-1:0] ADDR_CTRL    = 2'd0;
    localparam logic [CFG_AW-1:0] ADDR_ENABLE  = 2'd1;
    localparam logic [CFG_AW-1:0] ADDR_MODE    = 2'd2;
    localparam logic [CFG_AW-1:0] ADDR_PENDING = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: lowest set bit of the eligible vector wins.
module int_prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int unsigned N = NUM_IRQ_DEF
) (
    input  logic [N-1:0]    eligible,
    output logic            valid_c,
    output logic [ID_W-1:0] idx_c
);

    always_comb begin
        valid_c = 1'b0;
        idx_c   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                valid_c = 1'b1;
                idx_c   = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Vectored interrupt controller: edge/level sources, fixed priority, no nesting.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int unsigned        NUM_IRQ    = NUM_IRQ_DEF,
    parameter logic [VEC_W-1:0]   VEC_BASE   = 16'h0008,
    parameter int unsigned        VEC_STRIDE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [CFG_AW-1:0]  cfg_addr,
    input  logic [CFG_DW-1:0]  cfg_wdata,
    input  logic               cfg_we,
    input  logic               cfg_re,
    output logic [CFG_DW-1:0]  cfg_rdata,
    output logic               int_req,
    output logic [ID_W-1:0]    int_id,
    output logic [VEC_W-1:0]   int_vector,
    input  logic               int_ack,
    input  logic               int_done,
    output logic               in_service
);

    state_t               state_q, state_d;
    logic [NUM_IRQ-1:0]   irq_q, pend_q, pend_d;
    logic [NUM_IRQ-1:0]   enable_q, mode_q;
    logic                 gie_q;
    logic [ID_W-1:0]      id_q, id_d;
    logic                 req_q, req_d, svc_q, svc_d;
    logic [VEC_W-1:0]     vec_q, vec_d;
    logic [CFG_DW-1:0]    rdata_q, rdata_d;

    logic [NUM_IRQ-1:0]   rise_c, pending_c, eligible_c, id_onehot_c, cfg_clr_c, ack_mask_c;
    logic                 win_valid_c, ack_clr_c;
    logic [ID_W-1:0]      win_idx_c;
    logic                 unused_wdata;

    assign unused_wdata = &{1'b0, cfg_wdata[CFG_DW-1:NUM_IRQ]};

    // Edge bits live in pend_q; level bits read straight from the synchronised input.
    assign rise_c      = irq_in & ~irq_q;
    assign pending_c   = (pend_q & mode_q) | (irq_q & ~mode_q);
    assign eligible_c  = gie_q ? (pending_c & enable_q) : '0;
    assign id_onehot_c = NUM_IRQ'(1) << id_q;
    assign cfg_clr_c   = (cfg_we && cfg_addr == ADDR_PENDING) ?
                         (cfg_wdata[NUM_IRQ-1:0] & mode_q) : '0;

    int_prio_enc #(.N(NUM_IRQ)) u_prio_enc (
        .eligible (eligible_c),
        .valid_c  (win_valid_c),
        .idx_c    (win_idx_c)
    );

    // Next-state, latched id and registered output values.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        ack_clr_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_valid_c) begin
                    state_d = ST_REQ;
                    id_d    = win_idx_c;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    state_d   = ST_SERVICE;
                    ack_clr_c = 1'b1;
                end else if ((eligible_c & id_onehot_c) == '0) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (int_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_d = (state_d == ST_REQ);
        svc_d = (state_d == ST_SERVICE);
        vec_d = VEC_BASE + VEC_W'(id_d) * VEC_W'(VEC_STRIDE);
    end

    // A same-cycle edge beats the ack clear; a software clear beats the edge.
    always_comb begin
        ack_mask_c = ack_clr_c ? id_onehot_c : '0;
        pend_d     = ((pend_q & ~ack_mask_c) | rise_c) & ~cfg_clr_c & mode_q;
    end

    always_comb begin
        rdata_d = '0;
        case (cfg_addr)
            ADDR_CTRL:    rdata_d = CFG_DW'(gie_q);
            ADDR_ENABLE:  rdata_d = CFG_DW'(enable_q);
            ADDR_MODE:    rdata_d = CFG_DW'(mode_q);
            ADDR_PENDING: rdata_d = CFG_DW'(pending_c);
            default:      rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            irq_q    <= '0;
            pend_q   <= '0;
            gie_q    <= 1'b0;
            enable_q <= '0;
            mode_q   <= '0;
            id_q     <= '0;
            req_q    <= 1'b0;
            svc_q    <= 1'b0;
            vec_q    <= VEC_BASE;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_in;
            pend_q  <= pend_d;
            id_q    <= id_d;
            req_q   <= req_d;
            svc_q   <= svc_d;
            vec_q   <= vec_d;
            if (cfg_re) begin
                rdata_q <= rdata_d;
            end
            if (cfg_we) begin
                case (cfg_addr)
                    ADDR_CTRL:   gie_q    <= cfg_wdata[0];
                    ADDR_ENABLE: enable_q <= cfg_wdata[NUM_IRQ-1:0];
                    ADDR_MODE:   mode_q   <= cfg_wdata[NUM_IRQ-1:0];
                    default:     ;
                endcase
            end
        end
    end

    assign int_req    = req_q;
    assign int_id     = id_q;
    assign int_vector = vec_q;
    assign in_service = svc_q;
    assign cfg_rdata  = rdata_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl.
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  irq_in;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_wdata;
    logic        cfg_we, cfg_re;
    logic [7:0]  cfg_rdata;
    logic        int_req;
    logic [1:0]  int_id;
    logic [15:0] int_vector;
    logic        int_ack, int_done, in_service;

    int checks = 0;
    int errors = 0;

    int_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_we     (cfg_we),
        .cfg_re     (cfg_re),
        .cfg_rdata  (cfg_rdata),
        .int_req    (int_req),
        .int_id     (int_id),
        .int_vector (int_vector),
        .int_ack    (int_ack),
        .int_done   (int_done),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cfg_addr = a; cfg_wdata = d; cfg_we = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic cfg_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        cfg_addr = a; cfg_re = 1'b1;
        @(negedge clk);
        cfg_re = 1'b0;
        d = cfg_rdata;
    endtask

    task automatic pulse(input logic [2:0] bits);
        @(negedge clk);
        irq_in = irq_in | bits;
        @(negedge clk);
        irq_in = irq_in & ~bits;
    endtask

    task automatic do_ack();
        @(negedge clk);
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
    endtask

    task automatic do_done();
        @(negedge clk);
        int_done = 1'b1;
        @(negedge clk);
        int_done = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; irq_in = '0; cfg_we = 0; cfg_re = 0; int_ack = 0; int_done = 0;
        cfg_addr = '0; cfg_wdata = '0;
        wait_cycles(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        apply_reset();
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL reset_int_req got %b want 0", int_req); end
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL reset_in_service got %b want 0", in_service); end
        checks++; if (int_vector !== 16'h0008) begin errors++; $display("FAIL reset_vector got %h want 0008", int_vector); end
        checks++; if (int_id !== 2'd0) begin errors++; $display("FAIL reset_int_id got %0d want 0", int_id); end
        checks++; if (cfg_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", cfg_rdata); end
        for (int a = 0; a < 4; a++) begin
            cfg_read(2'(a), d);
            checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_reg%0d got %h want 00", a, d); end
        end
    endtask

    task automatic test_edge_basic();
        logic [7:0] d;
        cfg_write(2'd0, 8'h01);
        cfg_write(2'd1, 8'h07);
        cfg_write(2'd2, 8'h07);
        pulse(3'b010);
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL edge_latency_early got %b want 0", int_req); end
        @(negedge clk);
        checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL edge_int_req got %b want 1", int_req); end
        checks++; if (int_id !== 2'd1) begin errors++; $display("FAIL edge_int_id got %0d want 1", int_id); end
        checks++; if (int_vector !== 16'h000C) begin errors++; $display("FAIL edge_vector got %h want 000c", int_vector); end
        wait_cycles(3);
        checks++; if (int_req !== 1'b1 || int_id !== 2'd1) begin errors++; $display("FAIL edge_hold got req %b id %0d want 1 1", int_req, int_id); end
        do_ack();
        checks++; if (in_service !== 1'b1 || int_req !== 1'b0) begin errors++; $display("FAIL edge_service got svc %b req %b want 1 0", in_service, int_req); end
        cfg_read(2'd3, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL edge_pending_after_ack got %h want 00", d); end
        do_done();
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL edge_done got %b want 0", in_service); end
    endtask

    task automatic test_priority();
        logic [7:0] d;
        pulse(3'b101);
        @(negedge clk);
        checks++; if (int_req !== 1'b1 || int_id !== 2'd0) begin errors++; $display("FAIL prio_first got req %b id %0d want 1 0", int_req, int_id); end
        cfg_read(2'd3, d);
        checks++; if (d !== 8'h05) begin errors++; $display("FAIL prio_pending got %h want 05", d); end
        do_ack();
        do_done();
        @(negedge clk);
        checks++; if (int_req !== 1'b1 || int_id !== 2'd2) begin errors++; $display("FAIL prio_second got req %b id %0d want 1 2", int_req, int_id); end
        checks++; if (int_vector !== 16'h0010) begin errors++; $display("FAIL prio_vector got %h want 0010", int_vector); end
        do_ack();
        do_done();
    endtask

    task automatic test_level_drop();
        cfg_write(2'd2, 8'h06);
        @(negedge clk);
        irq_in[0] = 1'b1;
        wait_cycles(2);
        checks++; if (int_req !== 1'b1 || int_id !== 2'd0) begin errors++; $display("FAIL level_req got req %b id %0d want 1 0", int_req, int_id); end
        irq_in[0] = 1'b0;
        @(negedge clk);
        checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL level_still_held got %b want 1", int_req); end
        @(negedge clk);
        checks++; if (int_req !== 1'b0 || in_service !== 1'b0) begin errors++; $display("FAIL level_drop got req %b svc %b want 0 0", int_req, in_service); end
        wait_cycles(3);
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL level_idle got %b want 0", int_req); end
        cfg_write(2'd2, 8'h07);
    endtask

    task automatic test_enable_mask();
        logic [7:0] d;
        cfg_write(2'd1, 8'h00);
        pulse(3'b100);
        wait_cycles(3);
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL mask_no_req got %b want 0", int_req); end
        cfg_read(2'd3, d);
        checks++; if (d !== 8'h04) begin errors++; $display("FAIL mask_pending got %h want 04", d); end
        wait_cycles(2);
        checks++; if (cfg_rdata !== 8'h04) begin errors++; $display("FAIL rdata_hold got %h want 04", cfg_rdata); end
        cfg_write(2'd1, 8'h04);
        @(negedge clk);
        checks++; if (int_req !== 1'b1 || int_id !== 2'd2) begin errors++; $display("FAIL mask_enable got req %b id %0d want 1 2", int_req, int_id); end
        do_ack();
        do_done();
        cfg_write(2'd1, 8'h07);
    endtask

    task automatic test_pending_clear();
        logic [7:0] d;
        cfg_write(2'd1, 8'h00);
        pulse(3'b010);
        cfg_read(2'd3, d);
        checks++; if (d !== 8'h02) begin errors++; $display("FAIL clr_before got %h want 02", d); end
        cfg_write(2'd3, 8'h02);
        cfg_read(2'd3, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL clr_after got %h want 00", d); end
        cfg_write(2'd1, 8'h07);
        wait_cycles(2);
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL clr_no_req got %b want 0", int_req); end
    endtask

    task automatic test_no_nesting();
        pulse(3'b001);
        @(negedge clk);
        checks++; if (int_req !== 1'b1 || int_id !== 2'd0) begin errors++; $display("FAIL nest_first got req %b id %0d want 1 0", int_req, int_id); end
        do_ack();
        pulse(3'b010);
        wait_cycles(3);
        checks++; if (int_req !== 1'b0 || in_service !== 1'b1) begin errors++; $display("FAIL nest_blocked got req %b svc %b want 0 1", int_req, in_service); end
        do_done();
        @(negedge clk);
        checks++; if (int_req !== 1'b1 || int_id !== 2'd1) begin errors++; $display("FAIL nest_after got req %b id %0d want 1 1", int_req, int_id); end
        do_ack();
        do_done();
    endtask

    task automatic test_reset_in_service();
        logic [7:0] d;
        pulse(3'b100);
        @(negedge clk);
        do_ack();
        checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL rsvc_in_service got %b want 1", in_service); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (in_service !== 1'b0 || int_req !== 1'b0) begin errors++; $display("FAIL rsvc_outputs got svc %b req %b want 0 0", in_service, int_req); end
        checks++; if (int_vector !== 16'h0008 || int_id !== 2'd0) begin errors++; $display("FAIL rsvc_vector got %h id %0d want 0008 0", int_vector, int_id); end
        rst = 1'b0;
        for (int a = 0; a < 4; a++) begin
            cfg_read(2'(a), d);
            checks++; if (d !== 8'h00) begin errors++; $display("FAIL rsvc_reg%0d got %h want 00", a, d); end
        end
    endtask

    initial begin
        rst = 1'b1; irq_in = '0; cfg_addr = '0; cfg_wdata = '0;
        cfg_we = 0; cfg_re = 0; int_ack = 0; int_done = 0;
        test_reset();
        test_edge_basic();
        test_priority();
        test_level_drop();
        test_enable_mask();
        test_pending_clear();
        test_no_nesting();
        test_reset_in_service();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 3, number of interrupt sources (indices 0..NUM_IRQ-1).
REQ-002 SHALL have parameter VEC_BASE, default 16'h0008, handler address of source 0.
REQ-003 SHALL have parameter VEC_STRIDE, default 4, address spacing between handler entries.
REQ-004 SHALL have port clk, input, 1, the only clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port irq_in, input, NUM_IRQ, raw requests; bit i = interrupt_i.
REQ-007 SHALL have port cfg_addr, input, 2, register select: 0 CTRL, 1 ENABLE, 2 MODE, 3 PENDING.
REQ-008 SHALL have ports cfg_wdata (input, 8), cfg_we (input, 1), cfg_re (input, 1), cfg_rdata (output, 8), the CPU-side register port.
REQ-009 SHALL have port int_req, output, 1, interrupt request to the CPU.
REQ-010 SHALL have port int_id, output, 2, index of the requested source.
REQ-011 SHALL have port int_vector, output, 16, equal to VEC_BASE + int_id*VEC_STRIDE.
REQ-012 SHALL have ports int_ack, input, 1, CPU accepts the request, and int_done, input, 1, CPU returns from the handler.
REQ-013 SHALL have port in_service, output, 1, high while a handler runs.

Function
REQ-014 SHALL use these registers: CTRL bit0 = GIE; ENABLE[NUM_IRQ-1:0]; MODE bits (1 = rising edge, 0 = level high); PENDING, read-only except for write-1-to-clear.
REQ-015 SHALL register irq_in into irq_q every cycle and detect an edge as irq_in & ~irq_q.
REQ-016 SHALL set an edge-mode PENDING bit on a detected edge, regardless of ENABLE or GIE.
REQ-017 SHALL make a level-mode PENDING bit equal irq_q, and SHALL NOT latch it.
REQ-018 SHALL compute eligible = PENDING & ENABLE when GIE = 1, and 0 otherwise.
REQ-019 SHALL give fixed priority to the lowest index.
REQ-020 SHALL implement FSM states IDLE, REQ and SERVICE.
REQ-021 SHALL, in IDLE with eligible != 0, latch the winning index into int_id and enter REQ.
REQ-022 SHALL, in REQ, hold int_req = 1 with int_id and int_vector stable until int_ack.
REQ-023 SHALL, on int_ack in REQ, enter SERVICE and clear the edge-mode PENDING bit of int_id.
REQ-024 SHALL, if a new edge on the same source coincides with that clear, leave the bit set.
REQ-025 SHALL, in REQ without int_ack, return to IDLE with int_req = 0 the next cycle if the latched source is no longer eligible (masked, GIE cleared, level dropped); int_ack in that same cycle wins.
REQ-026 SHALL, in SERVICE, drive int_req = 0 and in_service = 1, issue no new request (no nesting), and return to IDLE on int_done.
REQ-027 SHALL ignore int_ack outside REQ and int_done outside SERVICE.
REQ-028 SHALL register int_req; an edge sampled at clock k SHALL give PENDING set after k and int_req = 1 after k+1 (2-cycle latency).
REQ-029 SHALL apply cfg_we writes at the clock edge; a PENDING write clears edge bits where cfg_wdata = 1 and ignores level bits.
REQ-030 SHALL let a PENDING clear override a same-cycle edge.
REQ-031 SHALL return registered cfg_rdata one cycle after cfg_re, with unused bits 0.
REQ-032 SHALL hold cfg_rdata when cfg_re = 0.
REQ-033 SHALL change configuration in REQ only through REQ-025; the latched int_id SHALL never change in REQ.

Reset
REQ-034 SHALL, on rst, clear CTRL, ENABLE, MODE, PENDING, irq_q, int_id and cfg_rdata, set state to IDLE, and drive int_req = 0, in_service = 0 and int_vector = VEC_BASE.
REQ-035 SHALL make rst mid-REQ or mid-SERVICE return to IDLE the next cycle with no ack required.
REQ-036 SHALL treat an input already high when rst falls as an edge, because irq_q resets to 0.

Structure
REQ-037 SHALL place the state enum, register address constants and the NUM_IRQ default in package int_ctrl_pkg.
REQ-038 SHALL use one combinational sub-module, int_prio_enc (eligible vector -> valid flag + lowest index).

Verification
REQ-039 SHALL cover: GIE = 1, ENABLE = 3'b111, MODE = 3'b111, pulse irq_in[1] -> int_req = 1 two cycles later, int_id = 1, int_vector = 16'h000C; after ack, PENDING = 3'b000.
REQ-040 SHALL cover: edges on sources 2 and 0 in the same cycle -> int_id = 0 first; after ack and done, int_id = 2 is served.
REQ-041 SHALL cover: level mode on source 0, irq_in[0] dropped while in REQ without ack -> int_req = 0 the next cycle and state IDLE.
REQ-042 SHALL cover: ENABLE = 0 with an edge on source 2 -> no int_req and PENDING reads 3'b100; then ENABLE[2] = 1 -> int_req asserts.
REQ-043 SHALL cover: edge on source 1 during SERVICE of source 0 -> no int_req until int_done, then int_id = 1.
REQ-044 SHALL cover: rst asserted in SERVICE -> in_service = 0, all registers read 0, int_vector = 16'h0008.
